// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock bank: lock FSM states and
// default sizing constants used by clk_div_bank and clk_div_ch.
package clk_div_pkg;

  // Default width of a per-channel divide ratio
  localparam int DEF_DIV_W    = 16;
  // Default number of settle cycles before locked asserts
  localparam int DEF_LOCK_CYC = 16;
  // Width of the lock counter; LOCK_CYC may be as large as 2^16-1
  localparam int LOCK_W       = 16;

  // Lock FSM: SETTLE after any realignment, LOCKED once the settle time elapses
  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: a modulo-D counter with registered clock and
// rising-edge strobe outputs. A load realigns the counter and forces both
// outputs low for one cycle so the first edge after realignment is clean.
// Optional feature macro: CLKDIV_PHASE_EN (counter starts at phase mod D).
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               DIV_W     = DEF_DIV_W,
  parameter logic [DIV_W-1:0] DEF_RATIO = DIV_W'(1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [DIV_W-1:0] ratio,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0] phase,
`endif
  output logic             outclk,
  output logic             outclk_en
);

  // A ratio of 0 behaves exactly like a ratio of 1
  localparam logic [DIV_W-1:0] DEF_EFF = (DEF_RATIO == '0) ? DIV_W'(1) : DEF_RATIO;

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic             outclk_reg;
  logic             outclk_en_reg;
  logic [DIV_W-1:0] ratio_eff;
  logic [DIV_W-1:0] high_cnt;
  logic [DIV_W-1:0] start_cnt;

  assign ratio_eff = (ratio == '0) ? DIV_W'(1) : ratio;
  // Number of high cycles per period: ceil(D/2), so odd ratios are high-biased
  assign high_cnt  = div_reg - (div_reg >> 1);

`ifdef CLKDIV_PHASE_EN
  assign start_cnt = phase % ratio_eff;
`else
  assign start_cnt = '0;
`endif

  // Counter, ratio capture and registered clock/strobe generation
  always_ff @(posedge clk) begin
    if (srst) begin
      div_reg       <= DEF_EFF;
      cnt_reg       <= '0;
      outclk_reg    <= 1'b0;
      outclk_en_reg <= 1'b0;
    end else if (load) begin
      div_reg       <= ratio_eff;
      cnt_reg       <= start_cnt;
      outclk_reg    <= 1'b0;
      outclk_en_reg <= 1'b0;
    end else begin
      cnt_reg       <= (cnt_reg == div_reg - DIV_W'(1)) ? '0 : cnt_reg + DIV_W'(1);
      outclk_reg    <= (cnt_reg < high_cnt);
      outclk_en_reg <= (cnt_reg == '0);
    end
  end

  assign outclk    = outclk_reg;
  assign outclk_en = outclk_en_reg;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers sharing one reference clock.
// cfg_load (or reset release) realigns every channel at once; locked reports
// that LOCK_CYC cycles have elapsed since the most recent realignment.
// Optional feature macro: CLKDIV_PHASE_EN adds the cfg_phase input.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      DIV_W    = DEF_DIV_W,
  parameter int                      LOCK_CYC = DEF_LOCK_CYC,
  parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV  = {16'd160, 16'd20}
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
`endif
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outclk_en,
  output logic                    locked
);

  // Last lock-counter value spent in SETTLE before moving to LOCKED
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);

  lock_state_t       state_reg, state_next;
  logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_div_ch #(
        .DIV_W     (DIV_W),
        .DEF_RATIO (DEF_DIV[gi*DIV_W +: DIV_W])
      ) u_ch (
        .clk       (refclk),
        .srst      (rst),
        .load      (cfg_load),
        .ratio     (cfg_div[gi*DIV_W +: DIV_W]),
`ifdef CLKDIV_PHASE_EN
        .phase     (cfg_phase[gi*DIV_W +: DIV_W]),
`endif
        .outclk    (outclk[gi]),
        .outclk_en (outclk_en[gi])
      );
    end
  endgenerate

  // Lock FSM state and settle counter registers
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg    <= SETTLE;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // Next-state logic: count settle cycles, any realignment restarts the count
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      SETTLE: begin
        if (lock_cnt_reg == LOCK_LAST) begin
          state_next = LOCKED;
        end else begin
          lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
        end
      end
      LOCKED: begin
        state_next = LOCKED;
      end
      default: begin
        state_next    = SETTLE;
        lock_cnt_next = '0;
      end
    endcase
    if (cfg_load) begin
      state_next    = SETTLE;
      lock_cnt_next = '0;
    end
  end

  assign locked = (state_reg == LOCKED);

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: a stimulus process drives resets and
// loads and pushes the expected per-cycle outputs from a period/phase model;
// a monitor pops and compares on the falling edge.
module tb_clk_div_bank;

  localparam int NUM_CH   = 2;
  localparam int DIV_W    = 16;
  localparam int LOCK_CYC = 16;
  localparam logic [NUM_CH*DIV_W-1:0] DEF_DIV = {16'd160, 16'd20};

  logic                    refclk = 1'b0;
  logic                    rst;
  logic                    cfg_load;
  logic [NUM_CH*DIV_W-1:0] cfg_div;
  logic [NUM_CH*DIV_W-1:0] cfg_phase;
  logic [NUM_CH-1:0]       outclk;
  logic [NUM_CH-1:0]       outclk_en;
  logic                    locked;

  always #5 refclk = ~refclk;

  clk_div_bank #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .LOCK_CYC (LOCK_CYC),
    .DEF_DIV  (DEF_DIV)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .cfg_load  (cfg_load),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] oc;
    logic [NUM_CH-1:0] en;
    logic              lk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: time of last realignment and per-channel period/phase
  int cyc     = 0;
  int align_t = 0;
  int div_m   [NUM_CH];
  int ph_m    [NUM_CH];

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Drive one cycle of inputs, then update the model and queue the expectation
  task automatic step(input logic r, input logic ld,
                      input logic [NUM_CH*DIV_W-1:0] dv,
                      input logic [NUM_CH*DIV_W-1:0] pv);
    exp_t e;
    int   p;
    rst       = r;
    cfg_load  = ld;
    cfg_div   = dv;
    cfg_phase = pv;
    @(posedge refclk);
    cyc++;
    if (r) begin
      align_t = cyc - 1;
      for (int i = 0; i < NUM_CH; i++) begin
        div_m[i] = eff(int'(DEF_DIV[i*DIV_W +: DIV_W]));
        ph_m[i]  = 0;
      end
    end else if (ld) begin
      align_t = cyc - 1;
      for (int i = 0; i < NUM_CH; i++) begin
        div_m[i] = eff(int'(dv[i*DIV_W +: DIV_W]));
`ifdef CLKDIV_PHASE_EN
        ph_m[i]  = int'(pv[i*DIV_W +: DIV_W]) % div_m[i];
`else
        ph_m[i]  = 0;
`endif
      end
    end
    e.cyc = cyc;
    e.oc  = '0;
    e.en  = '0;
    if (cyc > align_t + 1) begin
      for (int i = 0; i < NUM_CH; i++) begin
        p       = (ph_m[i] + cyc - (align_t + 2)) % div_m[i];
        e.oc[i] = (p < (div_m[i] + 1) / 2);
        e.en[i] = (p == 0);
      end
    end
    e.lk = (cyc >= align_t + 1 + LOCK_CYC);
    exp_q.push_back(e);
    #1;
  endtask

  // Free-run n cycles with random, unloaded cfg_div (must be ignored)
  task automatic run(input int n);
    logic [NUM_CH*DIV_W-1:0] junk;
    for (int k = 0; k < n; k++) begin
      junk = {$urandom, $urandom};
      step(1'b0, 1'b0, junk, junk);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (outclk !== e.oc) begin
          errors++;
          $display("FAIL outclk cyc=%0d got=%b want=%b", e.cyc, outclk, e.oc);
        end
        checks++;
        if (outclk_en !== e.en) begin
          errors++;
          $display("FAIL outclk_en cyc=%0d got=%b want=%b", e.cyc, outclk_en, e.en);
        end
        checks++;
        if (locked !== e.lk) begin
          errors++;
          $display("FAIL locked cyc=%0d got=%b want=%b", e.cyc, locked, e.lk);
        end
        $display("cyc=%0d outclk=%b outclk_en=%b locked=%b", e.cyc, outclk, outclk_en, locked);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH*DIV_W-1:0] dv;
    logic [NUM_CH*DIV_W-1:0] pv;
    int burst;
    rst       = 1'b1;
    cfg_load  = 1'b0;
    cfg_div   = '0;
    cfg_phase = '0;

    // Reset (with a load that must be ignored), then defaults 20/160
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, {16'd4, 16'd4}, '0);
    step(1'b1, 1'b0, '0, '0);
    run(340);

    // Ratios ch0=5, ch1=3
    step(1'b0, 1'b1, {16'd3, 16'd5}, '0);
    run(40);

    // Ratio 0 and ratio 1 on ch0
    step(1'b0, 1'b1, {16'd7, 16'd0}, '0);
    run(30);
    step(1'b0, 1'b1, {16'd2, 16'd1}, '0);
    run(25);

    // Load at T and again at T+8
    step(1'b0, 1'b1, {16'd6, 16'd4}, '0);
    run(7);
    step(1'b0, 1'b1, {16'd9, 16'd2}, '0);
    run(30);

    // Load held high for several cycles
    repeat (4) step(1'b0, 1'b1, {16'd5, 16'd6}, '0);
    run(25);

    // Reset pulse mid-LOCKED together with cfg_load
    step(1'b1, 1'b1, {16'd3, 16'd3}, '0);
    run(200);

`ifdef CLKDIV_PHASE_EN
    // Phase offset: ch0 phase 4, ch1 phase 0, both period 8
    step(1'b0, 1'b1, {16'd8, 16'd8}, {16'd0, 16'd4});
    run(30);
`endif

    // Randomized loads, bursts and occasional resets
    for (int k = 0; k < 30; k++) begin
      dv    = {16'($urandom_range(0, 12)), 16'($urandom_range(0, 12))};
      pv    = {16'($urandom_range(0, 20)), 16'($urandom_range(0, 20))};
      burst = $urandom_range(1, 3);
      for (int b = 0; b < burst; b++) begin
        step(($urandom_range(0, 9) == 0), 1'b1, dv, pv);
      end
      run($urandom_range(1, 45));
    end

    @(negedge refclk);
    @(negedge refclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of divided-clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 16, width of each channel divide ratio.
REQ-003 SHALL have parameter LOCK_CYC, default 16, settle cycles before locked asserts (1..2^16-1).
REQ-004 SHALL have parameter DEF_DIV, default {16'd160,16'd20}, packed NUM_CH*DIV_W reset ratios, ch0 in LSBs.
REQ-005 SHALL have port refclk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cfg_div  input  NUM_CH*DIV_W  new divide ratios, ch0 in LSBs.
REQ-008 SHALL have port cfg_load  input  1  one-cycle strobe capturing cfg_div and realigning all channels.
REQ-009 SHALL have port outclk  output  NUM_CH  divided clock per channel, registered.
REQ-010 SHALL have port outclk_en  output  NUM_CH  one-cycle strobe in the cycle outclk[i] rises, registered.
REQ-011 SHALL have port locked  output  1  high once all channels have run LOCK_CYC cycles since last alignment.

Function
REQ-012 Each channel SHALL run counter cnt 0..D-1 and wrap to 0, D = captured ratio; ratio 0 SHALL be treated as 1.
REQ-013 outclk[i] SHALL be 1 in the cycle after cnt < D-(D>>1), else 0 (D=5: 3 high/2 low; D=1: constant 1).
REQ-014 outclk_en[i] SHALL be 1 in the cycle after cnt==0 (every cycle for D=1).
REQ-015 FSM SHALL have states SETTLE and LOCKED; locked=1 only in LOCKED.
REQ-016 cfg_load sampled high in cycle T SHALL: capture cfg_div; all cnt=0 at T+1; lock counter cleared; state SETTLE at T+1.
REQ-017 After cfg_load at T, first outclk/outclk_en rising edge on all channels SHALL occur simultaneously at T+2.
REQ-018 SETTLE SHALL go to LOCKED when lock counter reaches LOCK_CYC; locked SHALL be 1 from cycle T+1+LOCK_CYC.
REQ-019 cfg_load in LOCKED SHALL drop locked at T+1; cfg_load in SETTLE SHALL restart lock count.
REQ-020 cfg_load held high for several cycles SHALL realign every cycle; locked stays 0 until LOCK_CYC cycles after the last one.
REQ-021 Counters SHALL never exceed D-1; width rules: cnt and ratio DIV_W bits unsigned, no overflow.

Reset
REQ-022 While rst=1: outclk=0, outclk_en=0, locked=0, all cnt=0, ratios=DEF_DIV, cfg_load ignored.
REQ-023 Reset release SHALL behave as cfg_load of DEF_DIV sampled in the last rst=1 cycle (R = first rst=0 cycle: edges at R+1, locked at R+LOCK_CYC).
REQ-024 rst asserted mid-operation SHALL override cfg_load and restore DEF_DIV next cycle.

Configuration
REQ-025 With CLKDIV_PHASE_EN defined, SHALL add input cfg_phase [NUM_CH*DIV_W], captured with cfg_load; cnt loaded to (phase mod D) instead of 0; reset phase 0.
REQ-026 Without CLKDIV_PHASE_EN, cfg_phase SHALL be absent and all channels align to cnt=0.

Structure
REQ-027 Package clk_div_pkg SHALL hold FSM state enum, default DIV_W/LOCK_CYC constants and lock-counter width.
REQ-028 Per-channel counter/compare SHALL be sub-module clk_div_ch, generated NUM_CH times; FSM and lock counter in top.

Verification
REQ-029 Reset release, defaults -> ch0 period 20 (10 high/10 low), ch1 period 160, edges coincide at R+1, locked at R+16.
REQ-030 cfg_load cfg_div={3,5} at T -> ch0 3 high/2 low, ch1 2 high/1 low, both edges at T+2, locked 0 T+1..T+16, 1 at T+17.
REQ-031 cfg_div ch0=0 and =1 -> outclk[0] constant 1, outclk_en[0] every cycle.
REQ-032 cfg_load at T and again at T+8 -> locked stays 0 until T+8+1+16.
REQ-033 rst pulse mid-LOCKED with cfg_load same cycle -> DEF_DIV restored, cfg_div ignored, locked 0.
REQ-034 CLKDIV_PHASE_EN, div={8,8}, phase={4,0} -> ch0 rises 4 cycles before ch1, both period 8.
